// File: rtl/adc_sample_packetizer_pkg.sv
// Shared constants and types for the ADC sample packetizer: word tags,
// FSM state encoding and the FIFO entry layout.
package adc_sample_packetizer_pkg;

    localparam logic [7:0] HEADER_MAGIC  = 8'hA5;
    localparam logic [7:0] TRAILER_MAGIC = 8'h5A;
    localparam logic [3:0] CH_A_TAG      = 4'h1;
    localparam logic [3:0] CH_B_TAG      = 4'h2;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        CH_A,
        CH_B,
        TRAILER
    } packetizer_state_t;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
    } sample_pair_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/adc_sample_packetizer_fifo.sv
// Sample-pair FIFO: power-of-two depth, wrap-bit pointers for full/empty,
// show-ahead read data. The caller decides when a write is allowed.
module sample_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/adc_sample_packetizer.sv
// Frames dual-channel 12-bit ADC pairs into 16-bit AXI-Stream packets:
// header, CH_A/CH_B words per pair, trailer carrying the drop count.
module adc_sample_packetizer
    import adc_sample_packetizer_pkg::*;
#(
    parameter int SAMPLES_PER_PACKET = 16,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [11:0] sample_ch_a,
    input  logic [11:0] sample_ch_b,
    output logic [15:0] packet_data_tdata,
    output logic        packet_data_tvalid,
    output logic        packet_data_tlast,
    input  logic        packet_data_tready,
    output logic [1:0]  packet_data_tkeep,
    output logic        packet_data_tid,
    output logic        packet_data_tdest,
    output logic        packet_data_tuser,
    output logic        overflow
);

    localparam logic [7:0] LAST_PAIR = 8'(SAMPLES_PER_PACKET - 1);

    packetizer_state_t state;
    packetizer_state_t next_state;

    sample_pair_t fifo_wr_pair;
    sample_pair_t fifo_rd_pair;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_wr;
    logic         fifo_pop;

    logic         accepting;
    logic         drop;
    logic         load_ok;
    logic         load;
    logic [15:0]  word_data;
    logic         word_last;

    logic [7:0]   pair_cnt;
    logic [7:0]   seq;
    logic [7:0]   drop_cnt;

    assign packet_data_tkeep = '1;
    assign packet_data_tid   = 1'b0;
    assign packet_data_tdest = 1'b0;
    assign packet_data_tuser = 1'b0;

    // Pairs are taken while a packet is open, or while idle and enabled.
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign accepting    = (state != IDLE) || enable;
    assign fifo_wr      = sample_valid && accepting && (!fifo_full || fifo_pop);
    assign drop         = sample_valid && accepting && fifo_full && !fifo_pop;
    assign fifo_wr_pair = '{a: sample_ch_a, b: sample_ch_b};

    // The output register may take a new word when empty or being drained this cycle.
    assign load_ok = !packet_data_tvalid || packet_data_tready;

    sample_pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(sample_pair_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wr_pair),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_pair),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable && !fifo_empty) next_state = HEADER;
            HEADER:  if (load) next_state = CH_A;
            CH_A:    if (load) next_state = CH_B;
            CH_B:    if (load) next_state = (pair_cnt == LAST_PAIR) ? TRAILER : CH_A;
            TRAILER: if (load) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // CH_A only peeks the FIFO head; CH_B consumes it once its word is loaded.
    always_comb begin
        load      = 1'b0;
        fifo_pop  = 1'b0;
        word_data = '0;
        word_last = 1'b0;
        case (state)
            HEADER: begin
                load      = load_ok;
                word_data = {HEADER_MAGIC, seq};
            end
            CH_A: begin
                load      = load_ok && !fifo_empty;
                word_data = {CH_A_TAG, fifo_rd_pair.a};
            end
            CH_B: begin
                load      = load_ok;
                fifo_pop  = load_ok;
                word_data = {CH_B_TAG, fifo_rd_pair.b};
            end
            TRAILER: begin
                load      = load_ok;
                word_data = {TRAILER_MAGIC, drop_cnt};
                word_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            packet_data_tdata  <= '0;
            packet_data_tvalid <= 1'b0;
            packet_data_tlast  <= 1'b0;
        end else if (load_ok) begin
            packet_data_tvalid <= load;
            packet_data_tlast  <= load && word_last;
            if (load) begin
                packet_data_tdata <= word_data;
            end
        end
    end

    // A drop coinciding with the trailer load belongs to the next packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq      <= '0;
            pair_cnt <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if ((state == HEADER) && load) begin
                seq <= seq + 8'd1;
            end
            if (fifo_pop) begin
                pair_cnt <= (pair_cnt == LAST_PAIR) ? 8'd0 : pair_cnt + 8'd1;
            end
            if ((state == TRAILER) && load) begin
                drop_cnt <= drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                drop_cnt <= sat_inc8(drop_cnt);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_packetizer.sv
// Bench for adc_sample_packetizer: a queue-based packet model fed with the
// pairs each scenario sends, compared against every handshaken output word.
`timescale 1ns/1ps
module tb_adc_sample_packetizer;

    localparam int SPP   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_ch_a = '0;
    logic [11:0] sample_ch_b = '0;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [1:0]  tkeep;
    logic        tid;
    logic        tdest;
    logic        tuser;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    int tready_mode = 0;   // 0 always ready, 1 toggle, 2 never, 3 random without two idle cycles in a row

    logic [16:0] got_q[$];  // {tlast, tdata} of each accepted word
    int          stall_err = 0;
    int          tvalid_cycles = 0;
    logic        stalled = 1'b0;
    logic [15:0] held = '0;

    logic [16:0] exp_q[$];
    logic [23:0] pend_q[$];
    logic [7:0]  model_seq = '0;

    adc_sample_packetizer #(
        .SAMPLES_PER_PACKET (SPP),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .sample_valid       (sample_valid),
        .sample_ch_a        (sample_ch_a),
        .sample_ch_b        (sample_ch_b),
        .packet_data_tdata  (tdata),
        .packet_data_tvalid (tvalid),
        .packet_data_tlast  (tlast),
        .packet_data_tready (tready),
        .packet_data_tkeep  (tkeep),
        .packet_data_tid    (tid),
        .packet_data_tdest  (tdest),
        .packet_data_tuser  (tuser),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        tready = 1'b1;
        forever begin
            @(negedge clk);
            case (tready_mode)
                1:       tready = (tready === 1'b1) ? 1'b0 : 1'b1;
                2:       tready = 1'b0;
                3:       tready = (tready === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b1;
                default: tready = 1'b1;
            endcase
        end
    end

    // Records the word that the coming rising edge will transfer, and watches held words.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n !== 1'b1) begin
                stalled = 1'b0;
            end else begin
                if (stalled && (tvalid !== 1'b1 || tdata !== held)) stall_err++;
                if (tvalid === 1'b1) tvalid_cycles++;
                if (tvalid === 1'b1 && tready === 1'b1) got_q.push_back({tlast, tdata});
                stalled = (tvalid === 1'b1) && (tready !== 1'b1);
                held    = tdata;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pair(input logic [11:0] a, input logic [11:0] b);
        sample_valid = 1'b1;
        sample_ch_a  = a;
        sample_ch_b  = b;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        cycles(2);
        model_seq = '0;
        pend_q.delete();
    endtask

    // Expected packet built straight from the framing rules.
    task automatic model_packet(input logic [7:0] drops);
        logic [23:0] p;
        exp_q.push_back({1'b0, 8'hA5, model_seq});
        for (int i = 0; i < SPP; i++) begin
            p = pend_q.pop_front();
            exp_q.push_back({1'b0, 4'h1, p[23:12]});
            exp_q.push_back({1'b0, 4'h2, p[11:0]});
        end
        exp_q.push_back({1'b1, 8'h5A, drops});
        model_seq = model_seq + 8'd1;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int left = budget;
        while (got_q.size() < n && left > 0) begin
            @(negedge clk);
            left--;
        end
        total++;
        if (got_q.size() < n) $display("FAIL %s timeout: got %0d words, required %0d", name, got_q.size(), n);
        else passed++;
    endtask

    task automatic test_reset();
        total++; if (tvalid !== 1'b0) $display("FAIL reset tvalid: got %b required 0", tvalid); else passed++;
        total++; if (tlast !== 1'b0) $display("FAIL reset tlast: got %b required 0", tlast); else passed++;
        total++; if (tdata !== 16'h0000) $display("FAIL reset tdata: got %h required 0000", tdata); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset overflow: got %b required 0", overflow); else passed++;
        total++;
        if ({tkeep, tid, tdest, tuser} !== 5'b11000)
            $display("FAIL reset constants: got %b required 11000", {tkeep, tid, tdest, tuser});
        else passed++;
    endtask

    task automatic test_basic();
        int          base = got_q.size();
        logic [16:0] w;
        logic [7:0]  b;
        logic [7:0]  bytes_exp [12] = '{8'h00, 8'hA5, 8'h23, 8'h11, 8'h56, 8'h24,
                                        8'h89, 8'h17, 8'hBC, 8'h2A, 8'h00, 8'h5A};
        exp_q.delete();
        enable = 1'b1;
        tready_mode = 0;
        pend_q.push_back({12'h123, 12'h456});
        pend_q.push_back({12'h789, 12'hABC});
        send_pair(12'h123, 12'h456);
        send_pair(12'h789, 12'hABC);
        model_packet(8'h00);
        wait_words(base + exp_q.size(), 100, "basic");
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL basic word %0d: got %h required %h", i, got_q[base + i], exp_q[i]);
            else passed++;
        end
        for (int i = 0; i < 12; i++) begin
            w = got_q[base + i / 2];
            b = (i % 2 == 0) ? w[7:0] : w[15:8];
            total++;
            if (b !== bytes_exp[i]) $display("FAIL byte order %0d: got %h required %h", i, b, bytes_exp[i]);
            else passed++;
        end
        cycles(10);
        total++;
        if (got_q.size() !== base + 6) $display("FAIL basic extra words: got %0d required %0d", got_q.size() - base, 6);
        else passed++;
    endtask

    task automatic test_backpressure();
        int base = got_q.size();
        exp_q.delete();
        tready_mode = 1;
        pend_q.push_back({12'h123, 12'h456});
        pend_q.push_back({12'h789, 12'hABC});
        send_pair(12'h123, 12'h456);
        send_pair(12'h789, 12'hABC);
        model_packet(8'h00);
        wait_words(base + exp_q.size(), 200, "backpressure");
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL backpressure word %0d: got %h required %h", i, got_q[base + i], exp_q[i]);
            else passed++;
        end
        total++;
        if (stall_err !== 0) $display("FAIL stall stability: got %0d changes required 0", stall_err);
        else passed++;
        tready_mode = 0;
        cycles(5);
    endtask

    task automatic test_overflow();
        int          base;
        logic [11:0] a;
        logic [11:0] b;
        exp_q.delete();
        tready_mode = 2;
        cycles(3);
        base = got_q.size();
        for (int i = 0; i < 7; i++) begin
            a = 12'($urandom);
            b = 12'($urandom);
            if (i < DEPTH) pend_q.push_back({a, b});
            send_pair(a, b);
        end
        cycles(3);
        total++; if (overflow !== 1'b1) $display("FAIL overflow flag: got %b required 1", overflow); else passed++;
        total++;
        if (got_q.size() !== base) $display("FAIL overflow stalled output: got %0d words required 0", got_q.size() - base);
        else passed++;
        tready_mode = 0;
        model_packet(8'h03);
        model_packet(8'h00);
        wait_words(base + exp_q.size(), 200, "overflow");
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL overflow word %0d: got %h required %h", i, got_q[base + i], exp_q[i]);
            else passed++;
        end
        total++; if (overflow !== 1'b1) $display("FAIL overflow sticky: got %b required 1", overflow); else passed++;
        cycles(5);
    endtask

    task automatic test_latency();
        int          base = got_q.size();
        logic [11:0] a2 = 12'($urandom);
        logic [11:0] b2 = 12'($urandom);
        logic [11:0] a1 = 12'($urandom);
        logic [11:0] b1 = 12'($urandom);
        exp_q.delete();
        tready_mode = 0;
        pend_q.push_back({a1, b1});
        pend_q.push_back({a2, b2});
        send_pair(a1, b1);
        wait_words(base + 3, 50, "latency first pair");
        cycles(2);
        total++; if (tvalid !== 1'b0) $display("FAIL latency wait idle: got tvalid %b required 0", tvalid); else passed++;
        sample_valid = 1'b1;
        sample_ch_a  = a2;
        sample_ch_b  = b2;
        @(negedge clk);
        sample_valid = 1'b0;
        total++; if (tvalid !== 1'b0) $display("FAIL latency one cycle: got tvalid %b required 0", tvalid); else passed++;
        @(negedge clk);
        total++;
        if (tvalid !== 1'b1 || tdata !== {4'h1, a2})
            $display("FAIL latency two cycles: got tvalid %b tdata %h required 1 %h", tvalid, tdata, {4'h1, a2});
        else passed++;
        model_packet(8'h00);
        wait_words(base + exp_q.size(), 50, "latency");
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL latency word %0d: got %h required %h", i, got_q[base + i], exp_q[i]);
            else passed++;
        end
        cycles(5);
    endtask

    task automatic test_enable();
        int          base = got_q.size();
        int          seen = tvalid_cycles;
        logic [11:0] a;
        logic [11:0] b;
        exp_q.delete();
        tready_mode = 0;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_pair(12'($urandom), 12'($urandom));
            cycles(2);
        end
        cycles(10);
        total++;
        if (tvalid_cycles !== seen) $display("FAIL disabled tvalid: got %0d valid cycles required 0", tvalid_cycles - seen);
        else passed++;
        enable = 1'b1;
        a = 12'($urandom); b = 12'($urandom);
        pend_q.push_back({a, b});
        send_pair(a, b);
        wait_words(base + 1, 50, "enable header");
        enable = 1'b0;
        a = 12'($urandom); b = 12'($urandom);
        pend_q.push_back({a, b});
        send_pair(a, b);
        model_packet(8'h00);
        wait_words(base + exp_q.size(), 50, "enable drop mid-packet");
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL enable word %0d: got %h required %h", i, got_q[base + i], exp_q[i]);
            else passed++;
        end
        cycles(5);
        send_pair(12'($urandom), 12'($urandom));
        cycles(20);
        total++;
        if (got_q.size() !== base + 6) $display("FAIL no header after disable: got %0d words required 6", got_q.size() - base);
        else passed++;
        enable = 1'b1;
        cycles(20);
        total++;
        if (got_q.size() !== base + 6) $display("FAIL idle pair discarded: got %0d words required 6", got_q.size() - base);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int          base;
        logic [11:0] a;
        logic [11:0] b;
        do_reset();
        exp_q.delete();
        enable = 1'b1;
        tready_mode = 3;
        base = got_q.size();
        for (int i = 0; i < 257 * SPP; i++) begin
            a = 12'($urandom); b = 12'($urandom);
            pend_q.push_back({a, b});
            send_pair(a, b);
            cycles(7);
        end
        for (int p = 0; p < 257; p++) model_packet(8'h00);
        wait_words(base + exp_q.size(), 300, "back to back");
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL b2b word %0d: got %h required %h", i, got_q[base + i], exp_q[i]);
            else passed++;
        end
        total++; if (overflow !== 1'b0) $display("FAIL b2b overflow: got %b required 0", overflow); else passed++;
        total++; if (stall_err !== 0) $display("FAIL b2b stall stability: got %0d changes required 0", stall_err); else passed++;
        tready_mode = 0;
        cycles(5);
    endtask

    task automatic test_reset_mid();
        int          base = got_q.size();
        logic [11:0] a;
        logic [11:0] b;
        exp_q.delete();
        tready_mode = 0;
        for (int i = 0; i < SPP; i++) begin
            a = 12'($urandom); b = 12'($urandom);
            pend_q.push_back({a, b});
            send_pair(a, b);
        end
        model_packet(8'h00);
        wait_words(base + 3, 50, "reset partial");
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL partial word %0d: got %h required %h", i, got_q[base + i], exp_q[i]);
            else passed++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (tvalid !== 1'b0) $display("FAIL mid reset tvalid: got %b required 0", tvalid); else passed++;
        total++; if (tlast !== 1'b0) $display("FAIL mid reset tlast: got %b required 0", tlast); else passed++;
        @(negedge clk);
        cycles(1);
        reset_n = 1'b1;
        model_seq = '0;
        pend_q.delete();
        exp_q.delete();
        cycles(2);
        base = got_q.size();
        for (int i = 0; i < SPP; i++) begin
            a = 12'($urandom); b = 12'($urandom);
            pend_q.push_back({a, b});
            send_pair(a, b);
        end
        model_packet(8'h00);
        wait_words(base + exp_q.size(), 50, "restart");
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[base + i] !== exp_q[i]) $display("FAIL restart word %0d: got %h required %h", i, got_q[base + i], exp_q[i]);
            else passed++;
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_latency();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
